// File: rtl/display_pkg.sv
// Shared screen encodings, FSM states, colour type and player palette for the
// multi-player LED display path.
package display_pkg;
  localparam int PLAYER_MAX = 8;

  typedef enum logic [1:0] {
    SCR_MENU      = 2'd0,
    SCR_COUNTDOWN = 2'd1,
    SCR_RACE      = 2'd2,
    SCR_WINNER    = 2'd3
  } screen_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t palette(input logic [2:0] idx, input logic [7:0] lvl);
    rgb_t c;
    c = '0;
    case (idx)
      3'd0: c.g = lvl;
      3'd1: c.r = lvl;
      3'd2: c.b = lvl;
      3'd3: begin c.r = lvl; c.g = lvl; end
      3'd4: begin c.r = lvl; c.b = lvl; end
      3'd5: begin c.g = lvl; c.b = lvl; end
      3'd6: begin c.r = lvl; c.g = lvl; c.b = lvl; end
      default: begin c.r = lvl; c.g = lvl >> 2; end
    endcase
    return c;
  endfunction
endpackage

// File: rtl/display_pixel_renderer.sv
// Combinational renderer: picks the screen for a snapshot and returns the
// colour of one LED on that screen.
module display_pixel_renderer
  import display_pkg::*;
#(
  parameter int         MAX_POS     = 16,
  parameter int         NUM_PLAYERS = 4,
  parameter int         POS_W       = $clog2(MAX_POS),
  parameter logic [7:0] INTENSITY   = 8'h0F,
  parameter int         BLEND       = 0
) (
  input  logic [NUM_PLAYERS-1:0]       player_ready,
  input  logic [NUM_PLAYERS*POS_W-1:0] player_pos,
  input  logic                         is_in_menu,
  input  logic [2:0]                   countdown,
  input  logic [POS_W-1:0]             index,
  output logic [1:0]                   screen,
  output rgb_t                         rgb
);
  logic                          win_hit;
  logic [$clog2(PLAYER_MAX)-1:0] win_idx;
  rgb_t                          race_rgb;
  rgb_t                          menu_rgb;

  // Descending scan so the lowest qualifying player is the last one written.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (player_ready[k] && player_pos[k*POS_W +: POS_W] == POS_W'(MAX_POS - 1)) begin
        win_hit = 1'b1;
        win_idx = 3'(k);
      end
    end
  end

  always_comb begin
    race_rgb = '0;
    menu_rgb = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (player_ready[k] && player_pos[k*POS_W +: POS_W] == index) begin
        if (BLEND != 0) race_rgb = race_rgb | palette(3'(k), INTENSITY);
        else            race_rgb = palette(3'(k), INTENSITY);
      end
      if (player_ready[k] && index == POS_W'(k)) menu_rgb = palette(3'(k), INTENSITY);
    end
  end

  always_comb begin
    screen = SCR_RACE;
    rgb    = race_rgb;
    if (win_hit) begin
      screen = SCR_WINNER;
      rgb    = palette(win_idx, INTENSITY);
    end else if (is_in_menu) begin
      screen = SCR_MENU;
      rgb    = menu_rgb;
    end else if (countdown != 3'd0) begin
      screen = SCR_COUNTDOWN;
      rgb    = '0;
      if (32'(index) < 32'(countdown)) rgb.r = INTENSITY;
    end
  end
endmodule

// File: rtl/multi_player_display_unit.sv
// Frame engine: latches redraw requests, snapshots the game inputs at frame
// start and streams one rendered LED frame over a valid/ready handshake.
module multi_player_display_unit
  import display_pkg::*;
#(
  parameter int         MAX_POS     = 16,
  parameter int         NUM_PLAYERS = 4,
  parameter int         POS_W       = $clog2(MAX_POS),
  parameter logic [7:0] INTENSITY   = 8'h0F,
  parameter int         BLEND       = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PLAYERS-1:0]       player_ready,
  input  logic [NUM_PLAYERS*POS_W-1:0] player_pos,
  input  logic [NUM_PLAYERS-1:0]       player_activity,
  input  logic                         menu_activity,
  input  logic                         clear,
  input  logic                         is_in_menu,
  input  logic [2:0]                   countdown,
  output logic [1:0]                   current_screen,
  output logic                         pixel_valid,
  input  logic                         pixel_ready,
  output logic [POS_W-1:0]             pixel_index,
  output logic [7:0]                   pixel_g,
  output logic [7:0]                   pixel_r,
  output logic [7:0]                   pixel_b,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         busy,
  output logic [1:0]                   debug_state
);
  // Handshake: a pixel transfers on every rising edge where pixel_valid and
  // pixel_ready are both high; pixel_valid never drops until its beat transfers,
  // and index/colour/frame_start hold while the beat waits.
  state_t                     state_q, state_d;
  logic                       pending_q;
  logic [NUM_PLAYERS-1:0]     snap_ready;
  logic [NUM_PLAYERS*POS_W-1:0] snap_pos;
  logic                       snap_menu;
  logic [2:0]                 snap_cd;
  logic                       req, start, fire, last;
  logic [NUM_PLAYERS-1:0]     r_ready;
  logic [NUM_PLAYERS*POS_W-1:0] r_pos;
  logic                       r_menu;
  logic [2:0]                 r_cd;
  logic [POS_W-1:0]           r_index;
  logic [1:0]                 r_screen;
  rgb_t                       r_rgb;

  assign req   = (|player_activity) | menu_activity | clear;
  assign start = (state_q == ST_IDLE) && (pending_q || req);
  assign fire  = pixel_valid && pixel_ready;
  assign last  = (pixel_index == POS_W'(MAX_POS - 1));

  // On the start edge the renderer sees the live inputs that are being captured,
  // so pixel 0 and the screen come from exactly the snapshot of this frame.
  assign r_ready = start ? player_ready : snap_ready;
  assign r_pos   = start ? player_pos   : snap_pos;
  assign r_menu  = start ? is_in_menu   : snap_menu;
  assign r_cd    = start ? countdown    : snap_cd;
  assign r_index = start ? '0 : pixel_index + POS_W'(1);

  display_pixel_renderer #(
    .MAX_POS(MAX_POS), .NUM_PLAYERS(NUM_PLAYERS), .POS_W(POS_W),
    .INTENSITY(INTENSITY), .BLEND(BLEND)
  ) u_renderer (
    .player_ready(r_ready), .player_pos(r_pos), .is_in_menu(r_menu),
    .countdown(r_cd), .index(r_index), .screen(r_screen), .rgb(r_rgb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (fire && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    frame_done  = (state_q == ST_DONE);
    debug_state = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q      <= 1'b1;
      snap_ready     <= '0;
      snap_pos       <= '0;
      snap_menu      <= 1'b0;
      snap_cd        <= '0;
      current_screen <= '0;
      pixel_valid    <= 1'b0;
      pixel_index    <= '0;
      pixel_g        <= '0;
      pixel_r        <= '0;
      pixel_b        <= '0;
      frame_start    <= 1'b0;
    end else begin
      pending_q <= start ? 1'b0 : (pending_q | req);
      if (start) begin
        snap_ready     <= player_ready;
        snap_pos       <= player_pos;
        snap_menu      <= is_in_menu;
        snap_cd        <= countdown;
        current_screen <= r_screen;
        pixel_valid    <= 1'b1;
        pixel_index    <= '0;
        frame_start    <= 1'b1;
        {pixel_g, pixel_r, pixel_b} <= r_rgb;
      end else if (fire) begin
        frame_start <= 1'b0;
        if (last) begin
          pixel_valid <= 1'b0;
        end else begin
          pixel_index <= r_index;
          {pixel_g, pixel_r, pixel_b} <= r_rgb;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_player_display_unit.sv
// Bench for multi_player_display_unit: two instances (BLEND 0 and 1) share the
// stimulus and are compared every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_multi_player_display_unit;
  localparam int MAX_POS = 16;
  localparam int NP      = 4;
  localparam int PW      = 4;
  localparam logic [23:0] PAL [8] = '{24'h0F0000, 24'h000F00, 24'h00000F, 24'h0F0F00,
                                      24'h000F0F, 24'h0F000F, 24'h0F0F0F, 24'h030F00};
  localparam logic [23:0] RED = 24'h000F00;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] player_ready = '0;
  logic [NP*PW-1:0] player_pos = '0;
  logic [NP-1:0] player_activity = '0;
  logic          menu_activity = 1'b0;
  logic          clear = 1'b0;
  logic          is_in_menu = 1'b0;
  logic [2:0]    countdown = '0;
  logic          pixel_ready = 1'b1;

  logic [1:0] o_screen [2];
  logic       o_valid  [2];
  logic [3:0] o_idx    [2];
  logic [7:0] o_g      [2];
  logic [7:0] o_r      [2];
  logic [7:0] o_b      [2];
  logic       o_fs     [2];
  logic       o_done   [2];
  logic       o_busy   [2];
  logic [1:0] o_dbg    [2];

  always #5 clk = ~clk;

  multi_player_display_unit #(.MAX_POS(MAX_POS), .NUM_PLAYERS(NP), .INTENSITY(8'h0F), .BLEND(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .player_ready(player_ready), .player_pos(player_pos),
    .player_activity(player_activity), .menu_activity(menu_activity), .clear(clear),
    .is_in_menu(is_in_menu), .countdown(countdown), .current_screen(o_screen[0]),
    .pixel_valid(o_valid[0]), .pixel_ready(pixel_ready), .pixel_index(o_idx[0]),
    .pixel_g(o_g[0]), .pixel_r(o_r[0]), .pixel_b(o_b[0]), .frame_start(o_fs[0]),
    .frame_done(o_done[0]), .busy(o_busy[0]), .debug_state(o_dbg[0]));

  multi_player_display_unit #(.MAX_POS(MAX_POS), .NUM_PLAYERS(NP), .INTENSITY(8'h0F), .BLEND(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .player_ready(player_ready), .player_pos(player_pos),
    .player_activity(player_activity), .menu_activity(menu_activity), .clear(clear),
    .is_in_menu(is_in_menu), .countdown(countdown), .current_screen(o_screen[1]),
    .pixel_valid(o_valid[1]), .pixel_ready(pixel_ready), .pixel_index(o_idx[1]),
    .pixel_g(o_g[1]), .pixel_r(o_r[1]), .pixel_b(o_b[1]), .frame_start(o_fs[1]),
    .frame_done(o_done[1]), .busy(o_busy[1]), .debug_state(o_dbg[1]));

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int edges = 0;
  int fs_count = 0;
  logic fs_prev = 1'b0;
  logic [23:0] cap [2][MAX_POS];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (o_fs[0] && !fs_prev) fs_count++;
    fs_prev = o_fs[0];
  end

  // ---------------- frame-level reference model ----------------
  int          m_phase;   // 0 idle, 1 scanning, 2 done
  bit          m_pend, m_valid, m_fs, m_req;
  int          m_idx;
  logic [1:0]  m_screen;
  logic [23:0] m_img [2][MAX_POS];

  function automatic void build_frame();
    int win;
    int p;
    win = -1;
    for (int k = NP - 1; k >= 0; k--)
      if (player_ready[k] && player_pos[k*PW +: PW] == 4'(MAX_POS - 1)) win = k;
    for (int i = 0; i < MAX_POS; i++) begin
      m_img[0][i] = '0;
      m_img[1][i] = '0;
    end
    if (win >= 0) begin
      m_screen = 2'd3;
      for (int i = 0; i < MAX_POS; i++) begin
        m_img[0][i] = PAL[win];
        m_img[1][i] = PAL[win];
      end
    end else if (is_in_menu) begin
      m_screen = 2'd0;
      for (int i = 0; i < NP; i++)
        if (player_ready[i]) begin
          m_img[0][i] = PAL[i];
          m_img[1][i] = PAL[i];
        end
    end else if (countdown != 3'd0) begin
      m_screen = 2'd1;
      for (int i = 0; i < int'(countdown); i++) begin
        m_img[0][i] = RED;
        m_img[1][i] = RED;
      end
    end else begin
      m_screen = 2'd2;
      for (int k = NP - 1; k >= 0; k--)
        if (player_ready[k]) begin
          p = int'(player_pos[k*PW +: PW]);
          m_img[0][p] = PAL[k];
          m_img[1][p] = m_img[1][p] | PAL[k];
        end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_pend = 1'b1; m_valid = 1'b0; m_fs = 1'b0; m_idx = 0; m_screen = '0;
    end else begin
      m_req = (player_activity != '0) || menu_activity || clear;
      case (m_phase)
        0: if (m_pend || m_req) begin
             build_frame();
             m_pend = 1'b0; m_phase = 1; m_valid = 1'b1; m_fs = 1'b1; m_idx = 0;
           end
        1: begin
             m_pend = m_pend || m_req;
             if (pixel_ready) begin
               m_fs = 1'b0;
               if (m_idx == MAX_POS - 1) begin m_valid = 1'b0; m_phase = 2; end
               else m_idx++;
             end
           end
        default: begin m_pend = m_pend || m_req; m_phase = 0; end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 64'(o_valid[d]), 64'(m_valid));
      chk("busy", d, 64'(o_busy[d]), 64'(m_phase != 0));
      chk("frame_done", d, 64'(o_done[d]), 64'(m_phase == 2));
      chk("state", d, 64'(o_dbg[d]), 64'(m_phase));
      chk("screen", d, 64'(o_screen[d]), 64'(m_screen));
      chk("frame_start", d, 64'(o_fs[d]), 64'(m_fs));
      if (m_valid) begin
        chk("index", d, 64'(o_idx[d]), 64'(m_idx));
        chk("colour", d, 64'({o_g[d], o_r[d], o_b[d]}), 64'(m_img[d][m_idx]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_pulses();
    player_activity = '0;
    menu_activity   = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_pulses();
    end
  endtask

  task automatic chk_reset(input string name);
    for (int d = 0; d < 2; d++)
      chk(name, d, 64'({o_valid[d], o_busy[d], o_done[d], o_fs[d], o_screen[d], o_idx[d],
                        o_g[d], o_r[d], o_b[d]}), 64'(0));
  endtask

  // Runs until frame_done; records the cycle of the first beat and of frame_done
  // and captures every transferred pixel of both instances.
  task automatic run_frame(input bit stall, input bit inject, output int first, output int done);
    int budget;
    first = -1;
    done = -1;
    budget = 0;
    for (int i = 0; i < MAX_POS; i++) begin
      cap[0][i] = 24'hFFFFFF;
      cap[1][i] = 24'hFFFFFF;
    end
    while (done < 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      clear_pulses();
      if (o_valid[0] && first < 0) first = edges;
      if (stall) pixel_ready = (first < 0) ? 1'b1 : (((edges - first) % 2) == 0);
      if (inject && o_valid[0] && pixel_ready && o_idx[0] == 4'd5) begin
        player_activity = 4'b0001;
        player_pos[3:0] = 4'd7;
      end
      if (o_valid[0] && pixel_ready) begin
        cap[0][o_idx[0]] = {o_g[0], o_r[0], o_b[0]};
        cap[1][o_idx[1]] = {o_g[1], o_r[1], o_b[1]};
      end
      if (o_done[0]) begin
        done = edges;
        if (inject) begin
          player_activity = 4'b0001;
          player_pos[3:0] = 4'd9;
        end
      end
    end
    chk("frame_timeout", 0, 64'(done < 0), 64'(0));
    pixel_ready = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int f, d, f2, d2, bad, fs_before, n;
    is_in_menu = 1'b1;
    player_ready = 4'b0101;
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    reset_n = 1'b1;

    // First frame after reset comes unprompted: menu with players 0 and 2.
    run_frame(1'b0, 1'b0, f, d);
    chk("menu_first_beat", 0, 64'(f), 64'(1));
    chk("menu_done_cycle", 0, 64'(d), 64'(17));
    chk("menu_screen", 0, 64'(o_screen[0]), 64'(0));
    chk("menu_px0_green", 0, 64'(cap[0][0]), 64'(24'h0F0000));
    chk("menu_px2_blue", 0, 64'(cap[0][2]), 64'(24'h00000F));
    bad = 0;
    for (int i = 0; i < MAX_POS; i++)
      if (i != 0 && i != 2 && cap[0][i] != 24'h0) bad++;
    chk("menu_others_off", 0, 64'(bad), 64'(0));

    // Race overlap: red (p1) and blue (p2) both at LED 5.
    @(negedge clk);
    is_in_menu = 1'b0; countdown = 3'd0; player_ready = 4'b0110;
    player_pos = 16'h0550; player_activity = 4'b0100;
    run_frame(1'b0, 1'b0, f, d);
    chk("race_screen", 0, 64'(o_screen[0]), 64'(2));
    chk("race_blend0_px5", 0, 64'(cap[0][5]), 64'(24'h000F00));
    chk("race_blend1_px5", 1, 64'(cap[1][5]), 64'(24'h000F0F));
    chk("race_px4_off", 1, 64'(cap[1][4]), 64'(0));

    // Countdown of 3.
    @(negedge clk);
    player_ready = 4'b0000; countdown = 3'd3; menu_activity = 1'b1;
    run_frame(1'b0, 1'b0, f, d);
    chk("cd_screen", 0, 64'(o_screen[0]), 64'(1));
    chk("cd_px2_red", 0, 64'(cap[0][2]), 64'(24'h000F00));
    chk("cd_px3_off", 0, 64'(cap[0][3]), 64'(0));

    // Alternating pixel_ready stalls.
    @(negedge clk);
    countdown = 3'd0; player_ready = 4'b0001; player_pos = 16'h0002; clear = 1'b1;
    run_frame(1'b1, 1'b0, f, d);
    chk("stall_done_latency", 0, 64'(d - f), 64'(31));
    chk("stall_px2_green", 0, 64'(cap[0][2]), 64'(24'h0F0000));

    // Requests during SCAN and DONE give exactly one extra frame.
    @(negedge clk);
    player_pos = 16'h0003; player_activity = 4'b0001;
    run_frame(1'b0, 1'b1, f, d);
    chk("snap_px3_green", 0, 64'(cap[0][3]), 64'(24'h0F0000));
    chk("snap_px7_off", 0, 64'(cap[0][7]), 64'(0));
    run_frame(1'b0, 1'b0, f2, d2);
    chk("extra_frame_start", 0, 64'(f2), 64'(d + 2));
    chk("extra_px9_green", 0, 64'(cap[0][9]), 64'(24'h0F0000));
    chk("extra_px7_off", 0, 64'(cap[0][7]), 64'(0));
    fs_before = fs_count;
    idle_cycles(40);
    chk("no_third_frame", 0, 64'(fs_count - fs_before), 64'(0));

    // Winner: yellow player 3 at the finish; unready players at 15 ignored.
    @(negedge clk);
    player_ready = 4'b1010; player_pos = 16'hFF3F; clear = 1'b1;
    run_frame(1'b0, 1'b0, f, d);
    chk("winner_screen", 0, 64'(o_screen[0]), 64'(3));
    for (int dd = 0; dd < 2; dd++) begin
      bad = 0;
      for (int i = 0; i < MAX_POS; i++)
        if (cap[dd][i] != 24'h0F0F00) bad++;
      chk("winner_all_yellow", dd, 64'(bad), 64'(0));
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    player_ready = 4'b0001; player_pos = 16'h0004; player_activity = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      clear_pulses();
      n++;
    end while (!(o_valid[0] && o_idx[0] == 4'd7) && n < 60);
    chk("reach_px7", 0, 64'(n >= 60), 64'(0));
    #2 reset_n = 1'b0;
    #1 chk_reset("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame(1'b0, 1'b0, f, d);
    chk("post_reset_first_beat", 0, 64'(f), 64'(1));
    chk("post_reset_done_cycle", 0, 64'(d), 64'(17));
    chk("post_reset_px4_green", 0, 64'(cap[0][4]), 64'(24'h0F0000));

    // Randomised traffic checked by the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      pixel_ready     = ($urandom_range(0, 9) < 7);
      player_activity = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      menu_activity   = ($urandom_range(0, 49) == 0);
      clear           = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) begin
        player_ready = 4'($urandom);
        player_pos   = 16'($urandom);
        is_in_menu   = ($urandom_range(0, 3) == 0);
        countdown    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      end
    end
    pixel_ready = 1'b1;
    idle_cycles(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
